if_id_reg: RTL and testbench

IF_ID_REG -- requirements
Module: if_id_reg

---
 rtl/if_id_reg.sv | 128 ++++++++++++
 tb/tb_if_id_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_reg.sv
// IF/ID pipeline register built as a 2-entry skid buffer (head + skid) with
// stall/flush control and MIPS-style field decode of the head instruction.
module if_id_reg #(
  parameter int unsigned IWIDTH   = 32,
  parameter int unsigned PCWIDTH  = 32,
  parameter int unsigned IMMWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IWIDTH-1:0]   in_instr,
  input  logic [PCWIDTH-1:0]  in_pc,
  input  logic                stall,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IWIDTH-1:0]   out_instr,
  output logic [PCWIDTH-1:0]  out_pc,
  output logic [5:0]          out_opcode,
  output logic [4:0]          out_rs,
  output logic [4:0]          out_rt,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_shamt,
  output logic [5:0]          out_funct,
  output logic [IMMWIDTH-1:0] out_imm
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [IWIDTH-1:0]  instr;
    logic [PCWIDTH-1:0] pc;
  } entry_t;

  state_t state, state_next;
  entry_t head, head_next;
  entry_t skid, skid_next;
  entry_t in_entry;
  logic   ready;
  logic   push, pop;

  assign in_entry = '{instr: in_instr, pc: in_pc};
  assign push     = in_valid && ready;
  assign pop      = out_valid && out_ready && !stall;

  // State and payload registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      head  <= head_next;
      skid  <= skid_next;
      // Tracks (state != TWO) but stays low while in reset.
      ready <= (state_next != TWO);
    end
  end

  // Next-state and payload movement.
  always_comb begin
    state_next = state;
    head_next  = head;
    skid_next  = skid;
    if (flush) begin
      state_next = EMPTY;
      head_next  = '0;
      skid_next  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_next  = in_entry;
            state_next = ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              skid_next  = in_entry;
              state_next = TWO;
            end
            2'b01: begin
              head_next  = '0;
              state_next = EMPTY;
            end
            2'b11: head_next = in_entry;
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            head_next  = skid;
            skid_next  = '0;
            state_next = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
          head_next  = '0;
          skid_next  = '0;
        end
      endcase
    end
  end

  assign in_ready  = ready;
  assign out_valid = (state != EMPTY);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  // Zero-latency field slices of the head instruction.
  assign out_opcode = head.instr[31:26];
  assign out_rs     = head.instr[25:21];
  assign out_rt     = head.instr[20:16];
  assign out_rd     = head.instr[15:11];
  assign out_shamt  = head.instr[10:6];
  assign out_funct  = head.instr[5:0];
  assign out_imm    = head.instr[IMMWIDTH-1:0];

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: reset, decode, skid, stall, flush,
// streaming and asynchronous mid-cycle reset.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm;

  int tests_run = 0;
  int tests_failed = 0;

  if_id_reg dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    tests_run++;
    if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_imm !== 16'h0 || out_opcode !== 6'h0)
      begin tests_failed++; $display("FAIL rst_fields instr %h pc %h exp 0", out_instr, out_pc); end
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready_before_edge got %b exp 0", in_ready); end
    step();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready_rise got %b exp 1", in_ready); end
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    push_word(32'h2008FFF8, 32'h00400000);
    tests_run++;
    if (out_valid !== 1'b1 || out_opcode !== 6'h08 || out_rs !== 5'd0 || out_rt !== 5'd8)
      begin tests_failed++; $display("FAIL decode_fields v %b op %h rs %0d rt %0d exp 1 08 0 8", out_valid, out_opcode, out_rs, out_rt); end
    tests_run++;
    if (out_imm !== 16'hFFF8 || out_pc !== 32'h00400000 || out_rd !== 5'd31 || out_funct !== 6'h38 || out_shamt !== 5'd31)
      begin tests_failed++; $display("FAIL decode_imm imm %h pc %h rd %0d fn %h sh %0d exp fff8 00400000 31 38 31", out_imm, out_pc, out_rd, out_funct, out_shamt); end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL decode_pop got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    push_word(32'h11111111, 32'h100);
    push_word(32'h22222222, 32'h104);
    tests_run++;
    if (in_ready !== 1'b0 || out_instr !== 32'h11111111 || out_valid !== 1'b1)
      begin tests_failed++; $display("FAIL skid_full rdy %b instr %h exp 0 11111111", in_ready, out_instr); end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_instr !== 32'h22222222 || out_pc !== 32'h104 || in_ready !== 1'b1)
      begin tests_failed++; $display("FAIL skid_drain instr %h pc %h rdy %b exp 22222222 104 1", out_instr, out_pc, in_ready); end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL skid_empty got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    push_word(32'h33333333, 32'h200);
    stall = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (out_instr !== 32'h33333333 || out_valid !== 1'b1)
        begin tests_failed++; $display("FAIL stall_hold[%0d] instr %h v %b exp 33333333 1", i, out_instr, out_valid); end
    end
    push_word(32'h44444444, 32'h204);
    tests_run++;
    if (in_ready !== 1'b0 || out_instr !== 32'h33333333)
      begin tests_failed++; $display("FAIL stall_push rdy %b instr %h exp 0 33333333", in_ready, out_instr); end
    stall = 1'b0;
    step();
    tests_run++;
    if (out_instr !== 32'h44444444 || in_ready !== 1'b1)
      begin tests_failed++; $display("FAIL stall_release instr %h rdy %b exp 44444444 1", out_instr, in_ready); end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_empty got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    push_word(32'h55555555, 32'h300);
    push_word(32'h66666666, 32'h304);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h77777777;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b1)
      begin tests_failed++; $display("FAIL flush_clear v %b instr %h rdy %b exp 0 0 1", out_valid, out_instr, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b0 || out_instr === 32'h77777777)
        begin tests_failed++; $display("FAIL flush_drop[%0d] v %b instr %h exp 0", i, out_valid, out_instr); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    push_word(32'd1, 32'h400);
    in_valid = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      tests_run++;
      if (out_instr !== 32'(k - 1) || in_ready !== 1'b1 || out_valid !== 1'b1)
        begin tests_failed++; $display("FAIL stream[%0d] instr %0d rdy %b exp %0d 1", k - 1, out_instr, in_ready, k - 1); end
      in_instr = 32'(k);
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_instr !== 32'd8 || in_ready !== 1'b1)
      begin tests_failed++; $display("FAIL stream[8] instr %0d rdy %b exp 8 1", out_instr, in_ready); end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_end got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    push_word(32'hAAAA0001, 32'h500);
    push_word(32'hBBBB0002, 32'h504);
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      begin tests_failed++; $display("FAIL arst_ctrl v %b rdy %b exp 0 0", out_valid, in_ready); end
    tests_run++;
    if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_rd !== 5'd0 || out_funct !== 6'd0 || out_imm !== 16'h0)
      begin tests_failed++; $display("FAIL arst_fields instr %h pc %h exp 0 0", out_instr, out_pc); end
    rst = 1'b0;
    step();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin tests_failed++; $display("FAIL arst_recover rdy %b v %b exp 1 0", in_ready, out_valid); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    stall = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_decode();
    test_skid();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
